rot_register_bank: RTL

Parametrised bank of rotating registers for the baby_vga peripheral, the successor to the fixed 16×4 rotating register file. It keeps two zero-latency combinational read ports and one addressed write port. It adds configurable depth and width, a ready/valid streaming load port with an auto-incrementing pointer, and per-register masked bit rotation. Rotation is driven either by an explicit strobe or by an internal prescaled auto-rotate timer. It sits between the tinyQV peripheral register interface and the VGA pattern generator.

---
 rtl/rot_bank_pkg.sv | 29 ++
 rtl/rot_cell.sv | 37 +++
 rtl/rot_register_bank.sv | 95 +++++++++
 3 files changed

// File: rtl/rot_bank_pkg.sv
// Shared constants and the single-step rotate helper for the rotating
// register bank.
package rot_bank_pkg;

    localparam int MAX_W = 16;

    localparam logic ROT_LEFT  = 1'b0;
    localparam logic ROT_RIGHT = 1'b1;

    // Rotate the low w bits of d by one place; bits above w stay 0.
    function automatic logic [MAX_W-1:0] rot1(
        input logic [MAX_W-1:0] d,
        input int               w,
        input logic             dir
    );
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                if (dir == ROT_LEFT)
                    r[i] = d[(i + w - 1) % w];
                else
                    r[i] = d[(i + 1) % w];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rot_cell.sv
// One register of the bank: random write beats stream write beats
// rotate, all resolved locally so a losing rotate only affects this cell.
module rot_cell
    import rot_bank_pkg::*;
#(
    parameter int                DATA_W    = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              st_en,
    input  logic [DATA_W-1:0] st_data,
    input  logic              rot_en,
    input  logic              rot_dir,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_rot;

    always_comb begin
        q_rot = DATA_W'(rot1(MAX_W'(q), DATA_W, rot_dir));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= RESET_VAL;
        else if (wr_en)
            q <= wr_data;
        else if (st_en)
            q <= st_data;
        else if (rot_en)
            q <= q_rot;
    end

endmodule

// File: rtl/rot_register_bank.sv
// Parametrised rotating register bank: two combinational read ports,
// addressed write, streaming load and masked strobe/auto rotation.
module rot_register_bank
    import rot_bank_pkg::*;
#(
    parameter int                NUM_REGS  = 16,
    parameter int                DATA_W    = 4,
    parameter int                ADDR_W    = $clog2(NUM_REGS),
    parameter int                PRESC_W   = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   r1_addr,
    input  logic [ADDR_W-1:0]   r2_addr,
    output logic [DATA_W-1:0]   data_out1,
    output logic [DATA_W-1:0]   data_out2,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                set_data,
    input  logic                stream_valid,
    input  logic [DATA_W-1:0]   stream_data,
    output logic                stream_ready,
    input  logic                stream_clear,
    output logic [ADDR_W-1:0]   stream_ptr,
    output logic                stream_last,
    input  logic                rot_en,
    input  logic                rot_dir,
    input  logic [NUM_REGS-1:0] rot_mask,
    input  logic                auto_rot,
    input  logic [PRESC_W-1:0]  rot_div,
    output logic                rot_tick
);

    localparam logic [ADDR_W:0]   NREGS = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0]  regs [NUM_REGS];
    logic [PRESC_W-1:0] count;
    logic               auto_tick;
    logic               st_fire;
    logic               r1_ok;
    logic               r2_ok;
    logic               w_ok;

    always_comb begin
        r1_ok        = {1'b0, r1_addr} < NREGS;
        r2_ok        = {1'b0, r2_addr} < NREGS;
        w_ok         = {1'b0, w_addr} < NREGS;
        stream_ready = !set_data && !stream_clear;
        st_fire      = stream_valid && stream_ready;
        stream_last  = (stream_ptr == LAST);
        auto_tick    = auto_rot && (count == rot_div);
        rot_tick     = rot_en || auto_tick;
        data_out1    = r1_ok ? regs[r1_addr] : '0;
        data_out2    = r2_ok ? regs[r2_addr] : '0;
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        rot_cell #(
            .DATA_W    (DATA_W),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (set_data && w_ok && (w_addr == ADDR_W'(i))),
            .wr_data (data_in),
            .st_en   (st_fire && (stream_ptr == ADDR_W'(i))),
            .st_data (stream_data),
            .rot_en  (rot_tick && rot_mask[i]),
            .rot_dir (rot_dir),
            .q       (regs[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stream_ptr <= '0;
        else if (stream_clear)
            stream_ptr <= '0;
        else if (st_fire)
            stream_ptr <= stream_last ? '0 : stream_ptr + 1'b1;
    end

    // Held at zero while disabled so re-enabling restarts a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (!auto_rot || auto_tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule
